mem_bist_sched: RTL and testbench



---
 rtl/mem_bist_pkg.sv | 26 ++
 rtl/mem_bist_sched_if.sv | 30 +++
 rtl/mem_bist_watchdog.sv | 30 +++
 rtl/mem_bist_sched.sv | 175 +++++++++++++++++
 tb/tb_mem_bist_sched.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the multi-bank BIST scheduler.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LAUNCH,
    WAIT,
    NEXT,
    FINISH
  } sched_state_t;

  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_TIMEOUT   = 1024;

  // Ceiling log2, used to size and cross-check index and counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_bist_sched_if.sv
// Handshake between the BIST scheduler (master) and the memory-test FSM (slave).
interface mem_bist_sched_if
  import mem_bist_pkg::*;
#(
  parameter int BANK_W = clog2(DEF_NUM_BANKS)
);

  logic [BANK_W-1:0] bank_sel;
  logic              bist_start;
  logic              bist_abort;
  logic              bist_done;
  logic              bist_fail;

  modport master (
    output bank_sel,
    output bist_start,
    output bist_abort,
    input  bist_done,
    input  bist_fail
  );

  modport slave (
    input  bank_sel,
    input  bist_start,
    input  bist_abort,
    output bist_done,
    output bist_fail
  );

endinterface

// File: rtl/mem_bist_watchdog.sv
// Per-bank watchdog: counts while enabled, flags expiry at TIMEOUT-1.
module mem_bist_watchdog
  import mem_bist_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = clog2(DEF_TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] ONE  = TO_W'(1);

  logic [TO_W-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      timer <= '0;
    end else if (en) begin
      timer <= timer + ONE;
    end
  end

  assign expired = en && (timer == LAST);

endmodule

// File: rtl/mem_bist_sched.sv
// Multi-bank BIST scheduler: runs the memory-test FSM once per enabled bank.
// Optional single retry of failing banks is enabled by defining MEM_BIST_RETRY_EN.
module mem_bist_sched
  import mem_bist_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int BANK_W    = clog2(DEF_NUM_BANKS),
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int TO_W      = clog2(DEF_TIMEOUT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_BANKS-1:0] bank_mask,
  mem_bist_sched_if.master     bist,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [NUM_BANKS-1:0] fail_map,
  output logic [NUM_BANKS-1:0] timeout_map
`ifdef MEM_BIST_RETRY_EN
  ,
  output logic [NUM_BANKS-1:0] retry_map
`endif
);

  localparam int             IW      = BANK_W + 1;
  localparam logic [IW-1:0]  IDX_END = IW'(NUM_BANKS);
  localparam logic [IW-1:0]  IDX_ONE = IW'(1);

  if (BANK_W != clog2(NUM_BANKS)) begin : g_bad_bank_w
    $error("mem_bist_sched: BANK_W must equal clog2(NUM_BANKS)");
  end
  if (TO_W != clog2(TIMEOUT)) begin : g_bad_to_w
    $error("mem_bist_sched: TO_W must equal clog2(TIMEOUT)");
  end
  if (NUM_BANKS < 2 || NUM_BANKS > 16 || TIMEOUT < 4) begin : g_bad_range
    $error("mem_bist_sched: NUM_BANKS must be 2..16 and TIMEOUT at least 4");
  end

  sched_state_t           state;
  logic [IW-1:0]          idx;
  logic [BANK_W-1:0]      bidx;
  logic [NUM_BANKS-1:0]   mask_q;
  logic [BANK_W-1:0]      bank_sel_q;
  logic                   bist_start_q;
  logic                   bist_abort_q;
  logic                   wd_clr;
  logic                   wd_en;
  logic                   wd_expired;
`ifdef MEM_BIST_RETRY_EN
  logic                   retry_pend;
`endif

  assign bidx = idx[BANK_W-1:0];

  // Watchdog restarts on every launch and only runs while waiting on the FSM.
  assign wd_clr = (state == LAUNCH);
  assign wd_en  = (state == WAIT);

  mem_bist_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      mask_q       <= '0;
      bank_sel_q   <= '0;
      bist_start_q <= 1'b0;
      bist_abort_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail_map     <= '0;
      timeout_map  <= '0;
`ifdef MEM_BIST_RETRY_EN
      retry_map    <= '0;
      retry_pend   <= 1'b0;
`endif
    end else begin
      bist_start_q <= 1'b0;
      bist_abort_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mask_q      <= bank_mask;
            fail_map    <= '0;
            timeout_map <= '0;
`ifdef MEM_BIST_RETRY_EN
            retry_map   <= '0;
            retry_pend  <= 1'b0;
`endif
            idx         <= '0;
            done        <= 1'b0;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (idx == IDX_END) begin
            state <= FINISH;
          end else if (!mask_q[bidx]) begin
            idx <= idx + IDX_ONE;
          end else begin
            bank_sel_q   <= bidx;
            bist_start_q <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT;
        end
        WAIT: begin
          // A completion in the expiry cycle is honoured; the timeout is dropped.
          if (bist.bist_done) begin
`ifdef MEM_BIST_RETRY_EN
            if (bist.bist_fail && !retry_map[bidx]) begin
              retry_map[bidx] <= 1'b1;
              retry_pend      <= 1'b1;
            end else begin
              fail_map[bidx]  <= bist.bist_fail;
            end
`else
            fail_map[bidx] <= bist.bist_fail;
`endif
            state <= NEXT;
          end else if (wd_expired) begin
            fail_map[bidx]    <= 1'b1;
            timeout_map[bidx] <= 1'b1;
            bist_abort_q      <= 1'b1;
            state             <= NEXT;
          end
        end
        NEXT: begin
`ifdef MEM_BIST_RETRY_EN
          if (retry_pend) begin
            retry_pend   <= 1'b0;
            bist_start_q <= 1'b1;
            state        <= LAUNCH;
          end else begin
            idx   <= idx + IDX_ONE;
            state <= SCAN;
          end
`else
          idx   <= idx + IDX_ONE;
          state <= SCAN;
`endif
        end
        FINISH: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          bank_sel_q <= '0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bist.bank_sel   = bank_sel_q;
  assign bist.bist_start = bist_start_q;
  assign bist.bist_abort = bist_abort_q;
  assign fail            = |fail_map;

endmodule

// File: tb/tb_mem_bist_sched.sv
// Directed bench for mem_bist_sched with a behavioural test-FSM responder.
module tb_mem_bist_sched;

  localparam int LAT = 10;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] bank_mask;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] fail_map;
  logic [3:0] timeout_map;
`ifdef MEM_BIST_RETRY_EN
  logic [3:0] retry_map;
`endif

  mem_bist_sched_if #(.BANK_W(2)) bist_if ();

  mem_bist_sched #(
    .NUM_BANKS (4),
    .BANK_W    (2),
    .TIMEOUT   (1024),
    .TO_W      (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bank_mask   (bank_mask),
    .bist        (bist_if.master),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .fail_map    (fail_map),
    .timeout_map (timeout_map)
`ifdef MEM_BIST_RETRY_EN
    ,
    .retry_map   (retry_map)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Responder: completes LAT cycles after each launch unless hang is set.
  logic       hang = 1'b0;
  logic [3:0] fail_pat = 4'b0000;
  logic [3:0] fail_once = 4'b0000;
  int         pend = 0;

  always @(negedge clk) begin
    bist_if.bist_done = 1'b0;
    bist_if.bist_fail = 1'b0;
    if (rst) begin
      pend = 0;
    end else if (bist_if.bist_start) begin
      pend = hang ? 0 : LAT;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bist_if.bist_done = 1'b1;
        bist_if.bist_fail = fail_pat[bist_if.bank_sel] | fail_once[bist_if.bank_sel];
        fail_once[bist_if.bank_sel] = 1'b0;
      end
    end
  end

  int          n;
  int          n_done;
  int          n_first;
  int          n_abort;
  int          nst;
  int          nab;
  logic [31:0] sels;
  logic        busy0;
  logic        timed_out;
  logic [1:0]  sel_at_rst;
  logic [3:0]  fm_at_rst;

  // n counts edges after the accepting edge; all sampling is on the falling edge.
  task automatic run(input logic [3:0] mask, input int inject_at, input int rst_at);
    logic fin;
    @(negedge clk);
    bank_mask = mask;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; n_done = -1; n_first = -1; n_abort = -1;
    nst = 0; nab = 0; sels = '0; timed_out = 1'b0; fin = 1'b0;
    busy0 = busy;
    while (!fin) begin
      if (bist_if.bist_start) begin
        if (nst == 0) n_first = n;
        nst++;
        sels = {sels[27:0], 2'b00, bist_if.bank_sel};
      end
      if (bist_if.bist_abort) begin
        if (nab == 0) n_abort = n;
        nab++;
      end
      if (done) begin
        n_done = n;
        fin = 1'b1;
      end else if (n == rst_at) begin
        sel_at_rst = bist_if.bank_sel;
        fm_at_rst = fail_map;
        rst = 1'b1;
        @(negedge clk);
        fin = 1'b1;
      end else if (n >= 5000) begin
        timed_out = 1'b1;
        fin = 1'b1;
      end else begin
        start = (n == inject_at);
        if (start) bank_mask = 4'b0000;
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_fmap"}, 32'(fail_map), 32'd0);
    chk({tag, "_tmap"}, 32'(timeout_map), 32'd0);
    chk({tag, "_sel"}, 32'(bist_if.bank_sel), 32'd0);
    chk({tag, "_bstart"}, 32'(bist_if.bist_start), 32'd0);
    chk({tag, "_babort"}, 32'(bist_if.bist_abort), 32'd0);
`ifdef MEM_BIST_RETRY_EN
    chk({tag, "_rmap"}, 32'(retry_map), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bank_mask = 4'b0000;
    bist_if.bist_done = 1'b0;
    bist_if.bist_fail = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Full mask, passing banks, with a start pulse injected while busy.
    run(4'b1111, 5, -1);
    chk("t1_tmo", 32'(timed_out), 32'd0);
    chk("t1_busy0", 32'(busy0), 32'd1);
    chk("t1_first_start", 32'(n_first), 32'd1);
    chk("t1_nstart", 32'(nst), 32'd4);
    chk("t1_sels", sels, 32'h0000_0123);
    chk("t1_done_lat", 32'(n_done), 32'd54);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_fail", 32'(fail), 32'd0);
    chk("t1_fmap", 32'(fail_map), 32'd0);
    chk("t1_tmap", 32'(timeout_map), 32'd0);
    chk("t1_nabort", 32'(nab), 32'd0);

    // Empty mask: skip every bank, no launches.
    run(4'b0000, -1, -1);
    chk("t4_done_lat", 32'(n_done), 32'd6);
    chk("t4_nstart", 32'(nst), 32'd0);
    chk("t4_fmap", 32'(fail_map), 32'd0);
    chk("t4_fail", 32'(fail), 32'd0);
    chk("t4_tmap", 32'(timeout_map), 32'd0);

    // Timeout on bank 2: launch edge 3, WAIT entry edge 4, abort edge 4+1024.
    hang = 1'b1;
    run(4'b0100, -1, -1);
    hang = 1'b0;
    chk("t3_tmo", 32'(timed_out), 32'd0);
    chk("t3_sels", sels, 32'h0000_0002);
    chk("t3_abort_at", 32'(n_abort), 32'd1028);
    chk("t3_nabort", 32'(nab), 32'd1);
    chk("t3_done_lat", 32'(n_done), 32'd1032);
    chk("t3_fmap", 32'(fail_map), 32'h4);
    chk("t3_tmap", 32'(timeout_map), 32'h4);
    chk("t3_fail", 32'(fail), 32'd1);

    // Sparse mask, bank 3 fails.
    fail_pat = 4'b1000;
    run(4'b1010, -1, -1);
    fail_pat = 4'b0000;
    chk("t2_tmo", 32'(timed_out), 32'd0);
    chk("t2_first_start", 32'(n_first), 32'd2);
    chk("t2_fmap", 32'(fail_map), 32'h8);
    chk("t2_tmap", 32'(timeout_map), 32'h0);
    chk("t2_fail", 32'(fail), 32'd1);
`ifdef MEM_BIST_RETRY_EN
    chk("t2_sels", sels, 32'h0000_0133);
    chk("t2_nstart", 32'(nst), 32'd3);
    chk("t2_done_lat", 32'(n_done), 32'd42);
    chk("t2_rmap", 32'(retry_map), 32'h8);
`else
    chk("t2_sels", sels, 32'h0000_0013);
    chk("t2_nstart", 32'(nst), 32'd2);
    chk("t2_done_lat", 32'(n_done), 32'd30);
`endif

    // Reset while waiting on bank 2 with bank 0 already recorded as failed.
    fail_pat = 4'b0001;
`ifdef MEM_BIST_RETRY_EN
    run(4'b1111, -1, 42);
`else
    run(4'b1111, -1, 30);
`endif
    chk("t5_sel_before", 32'(sel_at_rst), 32'd2);
    chk("t5_fmap_before", 32'(fm_at_rst), 32'h1);
    chk_zero("t5_rst");
    rst = 1'b0;
    fail_pat = 4'b0000;
    run(4'b0001, -1, -1);
    chk("t5_first_start", 32'(n_first), 32'd1);
    chk("t5_sels", sels, 32'h0000_0000);
    chk("t5_done_lat", 32'(n_done), 32'd18);
    chk("t5_fmap", 32'(fail_map), 32'h0);

`ifdef MEM_BIST_RETRY_EN
    // Bank 0 fails once then passes on the retry.
    fail_once = 4'b0001;
    run(4'b0001, -1, -1);
    chk("t6_nstart", 32'(nst), 32'd2);
    chk("t6_sels", sels, 32'h0000_0000);
    chk("t6_done_lat", 32'(n_done), 32'd30);
    chk("t6_rmap", 32'(retry_map), 32'h1);
    chk("t6_fmap", 32'(fail_map), 32'h0);
    chk("t6_fail", 32'(fail), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
